// File: rtl/prv32_div_seq.sv
// Sequential RV32M divider (DIV/DIVU/REM/REMU).
// Runs a 32-step restoring division through the shared EX-stage ALU.
// Divide-by-zero and signed overflow are resolved in IDLE without iterating.
module prv32_div_seq #(
    parameter logic [3:0] ALU_SUB_CODE = 4'b0001,
    parameter int         XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_fn,
    output logic            alu_own,
    input  logic [XLEN-1:0] alu_r,
    input  logic            alu_cf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    state_t          state_q, state_d;
    logic [XLEN-1:0] r_q, r_d;          // partial remainder
    logic [XLEN-1:0] n_q, n_d;          // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] d_q, d_d;          // divisor magnitude
    logic [4:0]      cnt_q, cnt_d;
    logic            rem_q, rem_d;      // 1 = remainder requested (op[1])
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    // Operand conditioning for the accept decision
    logic            signed_op;
    logic [XLEN-1:0] dividend_abs;
    logic [XLEN-1:0] divisor_abs;
    logic            div_by_zero;
    logic            sgn_overflow;

    // One iteration step: shift the next dividend bit into the remainder
    logic            iter_msb;
    logic [XLEN-1:0] iter_rs;
    logic            iter_ok;

    // Final sign correction
    logic [XLEN-1:0] q_fixed;
    logic [XLEN-1:0] r_fixed;

    assign signed_op    = ~op[0];
    assign dividend_abs = (signed_op & dividend[XLEN-1]) ? (ZERO - dividend) : dividend;
    assign divisor_abs  = (signed_op & divisor[XLEN-1])  ? (ZERO - divisor)  : divisor;
    assign div_by_zero  = (divisor == ZERO);
    assign sgn_overflow = signed_op & (dividend == MOST_NEG) & (divisor == ALL_ONES);

    assign iter_msb = r_q[XLEN-1];
    assign iter_rs  = {r_q[XLEN-2:0], n_q[XLEN-1]};
    // The shifted remainder is 33 bits wide; a set top bit always exceeds D.
    assign iter_ok  = iter_msb | alu_cf;

    assign q_fixed = qneg_q ? (ZERO - n_q) : n_q;
    assign r_fixed = rneg_q ? (ZERO - r_q) : r_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            r_q      <= ZERO;
            n_q      <= ZERO;
            d_q      <= ZERO;
            cnt_q    <= 5'd0;
            rem_q    <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            n_q      <= n_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath update; flush overrides everything
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        n_d      = n_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        done_d   = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (div_by_zero) begin
                            result_d = op[1] ? dividend : ALL_ONES;
                            done_d   = 1'b1;
                        end else if (sgn_overflow) begin
                            result_d = op[1] ? ZERO : MOST_NEG;
                            done_d   = 1'b1;
                        end else begin
                            n_d     = dividend_abs;
                            d_d     = divisor_abs;
                            r_d     = ZERO;
                            cnt_d   = 5'd0;
                            rem_d   = op[1];
                            qneg_d  = signed_op & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                            rneg_d  = signed_op & dividend[XLEN-1];
                            state_d = S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_d   = iter_ok ? alu_r : iter_rs;
                    n_d   = {n_q[XLEN-2:0], iter_ok};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = rem_q ? r_fixed : q_fixed;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ALU ownership: only ITER drives the shared ALU, otherwise everything is zero
    always_comb begin
        alu_own = 1'b0;
        alu_a   = ZERO;
        alu_b   = ZERO;
        alu_fn  = 4'd0;
        if (state_q == S_ITER) begin
            alu_own = 1'b1;
            alu_a   = iter_rs;
            alu_b   = d_q;
            alu_fn  = ALU_SUB_CODE;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
